// File: rtl/mul_pkg.sv
// Shared types and constants for the add-shift multiplier.
// Optional build macro MUL_SIGNED_EN (two's complement) is consumed by the datapath.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Counter must hold WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_add_shift_dp.sv
// Add-shift datapath: multiplicand, {accumulator, shift register} pair and product register.
// MUL_SIGNED_EN selects two's complement (arithmetic shift, subtract on the multiplier MSB).
module mul_add_shift_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic               capture,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mcand_x;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;

`ifndef MUL_SIGNED_EN
    logic last_unused;
    assign last_unused = last;
`endif

    always_comb begin
`ifdef MUL_SIGNED_EN
        mcand_x = {mcand_q[WIDTH-1], mcand_q};
`else
        mcand_x = {1'b0, mcand_q};
`endif
        addend = sr_q[0] ? mcand_x : '0;
`ifdef MUL_SIGNED_EN
        // Multiplier MSB carries negative weight in two's complement.
        sum = last ? (acc_q - addend) : (acc_q + addend);
`else
        sum = acc_q + addend;
`endif
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        prod_d  = prod_q;
        if (load) begin
            mcand_d = a;
            acc_d   = '0;
            sr_d    = b;
        end else if (step) begin
`ifdef MUL_SIGNED_EN
            acc_d = {sum[WIDTH], sum[WIDTH:1]};
`else
            acc_d = {1'b0, sum[WIDTH:1]};
`endif
            sr_d = {sum[0], sr_q[WIDTH-1:1]};
            if (capture) begin
                prod_d = {acc_d[WIDTH-1:0], sr_d};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            prod_q  <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/mul_add_shift_seq.sv
// Sequential add-shift multiplier top: FSM and bit counter driving the datapath strobes.
// Build macro MUL_SIGNED_EN switches the datapath to two's complement operands.
module mul_add_shift_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("mul_add_shift_seq: WIDTH out of range");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_last;
    logic          load, step, last, capture;

    // Handshake: start is a request taken on any edge where busy=0 (IDLE or DONE);
    // done pulses for one cycle when prod has just been loaded with a new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == CALC);
        done    = (state_q == DONE);
        load    = start && ((state_q == IDLE) || (state_q == DONE));
        step    = (state_q == CALC);
        last    = step && cnt_last;
        capture = step && cnt_last;
    end

    mul_add_shift_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .last    (last),
        .capture (capture),
        .a       (a),
        .b       (b),
        .prod    (prod)
    );

endmodule

// File: tb/tb_mul_add_shift_seq.sv
// Bench for mul_add_shift_seq: WIDTH=4 directed scenarios and WIDTH=8 randomized products.
// Reference model honours MUL_SIGNED_EN when the bundle is built with it.
module tb_mul_add_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  prod4;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    mul_add_shift_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .prod(prod4)
    );

    mul_add_shift_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .prod(prod8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Product of two w-bit operands, reduced to 2w bits.
    function automatic longint ref_mul(input int w, input longint a, input longint b);
        longint sa = a;
        longint sb = b;
`ifdef MUL_SIGNED_EN
        if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
        return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // driver: one start pulse on the 4-bit unit, waits (bounded) for done
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] p, output int lat, output int busy_cnt);
        a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (done4 !== 1'b1 && lat < 40) begin
            if (busy4 === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        p = prod4;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        total++; if (busy4 !== 1'b0)  begin bad++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        total++; if (done4 !== 1'b0)  begin bad++; $display("FAIL reset_done4: got %b want 0", done4); end
        total++; if (prod4 !== 8'h00) begin bad++; $display("FAIL reset_prod4: got %h want 00", prod4); end
        total++; if (busy8 !== 1'b0)  begin bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        total++; if (done8 !== 1'b0)  begin bad++; $display("FAIL reset_done8: got %b want 0", done8); end
        total++; if (prod8 !== 16'h0) begin bad++; $display("FAIL reset_prod8: got %h want 0000", prod8); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [7:0] p;
        int lat, bc;
        op4(4'b0110, 4'b0110, p, lat, bc);
        total++; if (p !== 8'h24) begin bad++; $display("FAIL basic_prod: got %h want 24", p); end
        total++; if (lat != 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        total++; if (bc != 4) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done4); end
        repeat (3) tick();
        total++; if (prod4 !== 8'h24) begin bad++; $display("FAIL basic_hold: got %h want 24", prod4); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e1, e2;
        int lat, gap;
        e1 = 8'(ref_mul(4, 7, 5));
        e2 = 8'(ref_mul(4, 15, 15));
        a4 = 4'b0111; b4 = 4'b0101; start4 = 1'b1;
        tick();
        a4 = 4'b1111; b4 = 4'b1111;
        lat = 0;
        while (done4 !== 1'b1 && lat < 40) begin tick(); lat++; end
        total++; if (lat != 4) begin bad++; $display("FAIL b2b_latency1: got %0d want 4", lat); end
        total++; if (prod4 !== e1) begin bad++; $display("FAIL b2b_prod1: got %h want %h", prod4, e1); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL b2b_busy_in_done: got %b want 0", busy4); end
        tick();
        start4 = 1'b0;
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL b2b_restart: got %b want 1", busy4); end
        total++; if (prod4 !== e1) begin bad++; $display("FAIL b2b_prod_held: got %h want %h", prod4, e1); end
        gap = 1;
        while (done4 !== 1'b1 && gap < 40) begin tick(); gap++; end
        total++; if (gap != 5) begin bad++; $display("FAIL b2b_spacing: got %0d want 5", gap); end
        total++; if (prod4 !== e2) begin bad++; $display("FAIL b2b_prod2: got %h want %h", prod4, e2); end
        tick();
    endtask

    task automatic test_start_ignored;
        logic [7:0] p, pdone, e;
        int lat, bc, ndone, first;
        op4(4'b0000, 4'b1011, p, lat, bc);
        total++; if (p !== 8'h00) begin bad++; $display("FAIL zero_prod: got %h want 00", p); end
        e = 8'(ref_mul(4, 5, 3));
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        ndone = 0; first = -1; pdone = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (done4 === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
                pdone = prod4;
            end
            tick();
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        total++; if (first != 1) begin bad++; $display("FAIL ignore_done_time: got %0d want 1", first); end
        total++; if (pdone !== e) begin bad++; $display("FAIL ignore_prod: got %h want %h", pdone, e); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] p;
        int lat, bc, nd;
        a4 = 4'd9; b4 = 4'd13; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (prod4 !== 8'h00) begin bad++; $display("FAIL rstmid_prod: got %h want 00", prod4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy4); end
        tick();
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4 === 1'b1 || busy4 === 1'b1) nd++;
            tick();
        end
        total++; if (nd != 0) begin bad++; $display("FAIL rstmid_activity: got %0d want 0", nd); end
        op4(4'b0101, 4'b0101, p, lat, bc);
        total++; if (p !== 8'h19) begin bad++; $display("FAIL rstmid_next_prod: got %h want 19", p); end
        total++; if (lat != 4) begin bad++; $display("FAIL rstmid_next_latency: got %0d want 4", lat); end
    endtask

    task automatic test_extremes;
        logic [7:0] p, w1, w2, w3;
        int lat, bc;
`ifdef MUL_SIGNED_EN
        w1 = 8'h40; w2 = 8'hF9; w3 = 8'hC8;
`else
        w1 = 8'h40; w2 = 8'h69; w3 = 8'h38;
`endif
        op4(4'b1000, 4'b1000, p, lat, bc);
        total++; if (p !== w1) begin bad++; $display("FAIL ext_8x8: got %h want %h", p, w1); end
        op4(4'b1111, 4'b0111, p, lat, bc);
        total++; if (p !== w2) begin bad++; $display("FAIL ext_f_x_7: got %h want %h", p, w2); end
        op4(4'b0111, 4'b1000, p, lat, bc);
        total++; if (p !== w3) begin bad++; $display("FAIL ext_7_x_8: got %h want %h", p, w3); end
    endtask

    task automatic test_random8;
        logic [7:0]  ra, rb;
        logic [15:0] got, exp;
        int lat, gap;
        for (int i = 0; i < 1000; i++) begin
            ra = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom_range(0, 255));
            rb = (i == 0) ? 8'hFF : (i == 1) ? 8'hC8 : 8'($urandom_range(0, 255));
            exp_q.push_back(16'(ref_mul(8, longint'(ra), longint'(rb))));
            a8 = ra; b8 = rb; start8 = 1'b1;
            tick();
            start8 = 1'b0;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            lat = 0;
            while (done8 !== 1'b1 && lat < 40) begin tick(); lat++; end
            total++; if (lat != 8) begin bad++; $display("FAIL rand8_latency[%0d]: got %0d want 8", i, lat); end
            got = prod8;
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand8_prod[%0d] a=%h b=%h: got %h want %h", i, ra, rb, got, exp);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
        end
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_extremes();
        test_random8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
